// File: rtl/ddr3_rw_arbiter_pkg.sv
// Shared definitions for the DDR3 read/write arbiter: app command
// encodings, FSM state encoding and parameter defaults.
// The address and data width defaults can be overridden at build time
// through the MEM_ADDR_SIZE and CACHE_WIDTH macros.

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 28
`endif

`ifndef CACHE_WIDTH
`define CACHE_WIDTH 128
`endif

package ddr3_rw_arbiter_pkg;

  localparam int DEF_MEM_ADDR_SIZE = `MEM_ADDR_SIZE;
  localparam int DEF_CACHE_WIDTH   = `CACHE_WIDTH;
  localparam int DEF_WR_RUN_MAX    = 8;
  localparam int DEF_RD_OUTST_MAX  = 16;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ddr3_rd_outst_cnt.sv
// Saturating up/down counter of read bursts issued but not yet returned.
// An increment and a decrement in the same cycle cancel out; the count
// never wraps past 0 or past MAX.

module ddr3_rd_outst_cnt #(
  parameter int MAX = 16,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign count = count_reg;
  assign full  = (count_reg == W'(MAX));
  assign empty = (count_reg == '0);

  // Next count: single-sided moves only, clamped at both ends.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec && !full) begin
      count_next = count_reg + W'(1);
    end else if (dec && !inc && !empty) begin
      count_next = count_reg - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Arbitrates the single DDR3 app command port between the write stream and
// the read stream. One burst per grant, outstanding reads are tracked and
// no grant is made before calibration completes.
// Optional feature macro ARB_STARVE_GUARD_EN: after WR_RUN_MAX consecutive
// write grants a waiting read is forced ahead of the next write. Without it
// writes have strict priority.

module ddr3_rw_arbiter
  import ddr3_rw_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int CACHE_WIDTH   = DEF_CACHE_WIDTH,
  parameter int WR_RUN_MAX    = DEF_WR_RUN_MAX,
  parameter int RD_OUTST_MAX  = DEF_RD_OUTST_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_calib_complete,
  input  logic                     wr_req,
  input  logic [MEM_ADDR_SIZE-1:0] wr_addr,
  input  logic [CACHE_WIDTH-1:0]   wr_data,
  output logic                     wr_ack,
  input  logic                     rd_req,
  input  logic [MEM_ADDR_SIZE-1:0] rd_addr,
  output logic                     rd_ack,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [MEM_ADDR_SIZE-1:0] app_addr,
  input  logic                     app_rdy,
  output logic                     app_wdf_wren,
  output logic [CACHE_WIDTH-1:0]   app_wdf_data,
  output logic                     app_wdf_end,
  input  logic                     app_wdf_rdy,
  input  logic                     app_rd_data_valid,
  output logic [4:0]               rd_outst
);

  arb_state_t               state_reg, state_next;
  logic                     app_en_reg, app_en_next;
  logic                     app_wdf_wren_reg, app_wdf_wren_next;
  logic [2:0]               app_cmd_reg, app_cmd_next;
  logic [MEM_ADDR_SIZE-1:0] app_addr_reg, app_addr_next;
  logic [CACHE_WIDTH-1:0]   app_wdf_data_reg, app_wdf_data_next;
  logic                     wr_ack_reg, wr_ack_next;
  logic                     rd_ack_reg, rd_ack_next;

  logic wr_grant;
  logic rd_grant;
  logic rd_forced;
  logic rd_full;
  logic rd_empty;
  logic cmd_done;
  logic data_done;
  logic rd_issue;
  logic rd_return;

  // A side of the write handshake is done if it was already accepted
  // earlier or is being accepted this cycle.
  assign cmd_done  = !app_en_reg || app_rdy;
  assign data_done = !app_wdf_wren_reg || app_wdf_rdy;

  // A return with nothing outstanding is spurious; it is dropped before it
  // could cancel a concurrent issue.
  assign rd_issue  = (state_reg == ST_RD) && app_rdy;
  assign rd_return = app_rd_data_valid && !rd_empty;

  ddr3_rd_outst_cnt #(
    .MAX (RD_OUTST_MAX),
    .W   (5)
  ) u_rd_outst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_issue),
    .dec   (rd_return),
    .count (rd_outst),
    .full  (rd_full),
    .empty (rd_empty)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(WR_RUN_MAX + 1);

  logic [RUN_W-1:0] wr_run_reg, wr_run_next;

  // Consecutive write grants while a read is waiting, saturating.
  always_comb begin
    wr_run_next = wr_run_reg;
    if (rd_grant || (state_reg == ST_IDLE && !rd_req)) begin
      wr_run_next = '0;
    end else if (wr_grant && wr_run_reg != RUN_W'(WR_RUN_MAX)) begin
      wr_run_next = wr_run_reg + RUN_W'(1);
    end
  end

  // Write-run register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_run_reg <= '0;
    end else begin
      wr_run_reg <= wr_run_next;
    end
  end

  assign rd_forced = (wr_run_reg == RUN_W'(WR_RUN_MAX));
`else
  assign rd_forced = 1'b0;
`endif

  // Grant selection, burst sequencing and next values of all outputs.
  always_comb begin
    state_next        = state_reg;
    app_en_next       = app_en_reg;
    app_wdf_wren_next = app_wdf_wren_reg;
    app_cmd_next      = app_cmd_reg;
    app_addr_next     = app_addr_reg;
    app_wdf_data_next = app_wdf_data_reg;
    wr_ack_next       = 1'b0;
    rd_ack_next       = 1'b0;
    wr_grant          = 1'b0;
    rd_grant          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // The ack cycle is spent here without granting: the requester
        // still holds its old request during that cycle.
        if (init_calib_complete && !wr_ack_reg && !rd_ack_reg) begin
          if (rd_req && rd_forced && !rd_full) begin
            rd_grant = 1'b1;
          end else if (wr_req) begin
            wr_grant = 1'b1;
          end else if (rd_req && !rd_full) begin
            rd_grant = 1'b1;
          end
        end
        if (wr_grant) begin
          state_next        = ST_WR;
          app_en_next       = 1'b1;
          app_wdf_wren_next = 1'b1;
          app_cmd_next      = APP_CMD_WR;
          app_addr_next     = wr_addr;
          app_wdf_data_next = wr_data;
        end else if (rd_grant) begin
          state_next    = ST_RD;
          app_en_next   = 1'b1;
          app_cmd_next  = APP_CMD_RD;
          app_addr_next = rd_addr;
        end
      end
      ST_WR: begin
        if (app_rdy) begin
          app_en_next = 1'b0;
        end
        if (app_wdf_rdy) begin
          app_wdf_wren_next = 1'b0;
        end
        if (cmd_done && data_done) begin
          wr_ack_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_RD: begin
        if (app_rdy) begin
          app_en_next = 1'b0;
          rd_ack_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      app_en_reg       <= 1'b0;
      app_wdf_wren_reg <= 1'b0;
      app_cmd_reg      <= APP_CMD_WR;
      app_addr_reg     <= '0;
      app_wdf_data_reg <= '0;
      wr_ack_reg       <= 1'b0;
      rd_ack_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      app_en_reg       <= app_en_next;
      app_wdf_wren_reg <= app_wdf_wren_next;
      app_cmd_reg      <= app_cmd_next;
      app_addr_reg     <= app_addr_next;
      app_wdf_data_reg <= app_wdf_data_next;
      wr_ack_reg       <= wr_ack_next;
      rd_ack_reg       <= rd_ack_next;
    end
  end

  assign app_en       = app_en_reg;
  assign app_wdf_wren = app_wdf_wren_reg;
  assign app_wdf_end  = app_wdf_wren_reg;
  assign app_cmd      = app_cmd_reg;
  assign app_addr     = app_addr_reg;
  assign app_wdf_data = app_wdf_data_reg;
  assign wr_ack       = wr_ack_reg;
  assign rd_ack       = rd_ack_reg;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Self-checking bench for ddr3_rw_arbiter: directed scenarios followed by
// a randomized phase checked against a transaction-level model.
// Honours ARB_STARVE_GUARD_EN for the write/read interleave expectation.

module tb_ddr3_rw_arbiter;

  localparam int AW = 28;
  localparam int DW = 64;
  localparam int RUN_MAX = 8;
  localparam int OUTST_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_calib_complete;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic          app_rd_data_valid;
  logic [4:0]    rd_outst;

  int errors = 0;
  int checks = 0;

  ddr3_rw_arbiter #(
    .MEM_ADDR_SIZE (AW),
    .CACHE_WIDTH   (DW),
    .WR_RUN_MAX    (RUN_MAX),
    .RD_OUTST_MAX  (OUTST_MAX)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_ack              (wr_ack),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_ack              (rd_ack),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .rd_outst            (rd_outst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " app_en"}, app_en, 0);
    chk({tag, " app_wdf_wren"}, app_wdf_wren, 0);
    chk({tag, " app_wdf_end"}, app_wdf_end, 0);
    chk({tag, " app_cmd"}, app_cmd, 0);
    chk({tag, " app_addr"}, app_addr, 0);
    chk({tag, " app_wdf_data"}, app_wdf_data, 0);
    chk({tag, " wr_ack"}, wr_ack, 0);
    chk({tag, " rd_ack"}, rd_ack, 0);
    chk({tag, " rd_outst"}, rd_outst, 0);
  endtask

  initial begin
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    int  n_ack;
    int  n_en;
    int  n_rd;
    bit  found;
    bit  exp_rd;
    int  model_outst;
    bit  exp_wack, exp_rack, w_cmd_seen, w_dat_seen, wr_drop, rd_drop, rd_acc;

    rst_n = 1'b0;
    init_calib_complete = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle gating: a write request must wait for calibration
    a0 = 28'h0ABCDE1;
    d0 = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a0; wr_data = d0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("gate app_en", app_en, 0);
      @(posedge clk); #1;
    end
    init_calib_complete = 1'b1;
    @(negedge clk);
    chk("grant cycle app_en", app_en, 0);

    // Split write handshake, cycle 1 = first WR cycle
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      app_wdf_rdy = (c == 3);
      app_rdy = (c == 6);
      if (c == 8) wr_req = 1'b0;
      @(negedge clk);
      chk($sformatf("split c%0d app_en", c), app_en, (c <= 6));
      chk($sformatf("split c%0d wren", c), app_wdf_wren, (c <= 3));
      chk($sformatf("split c%0d wdf_end", c), app_wdf_end, (c <= 3));
      chk($sformatf("split c%0d wr_ack", c), wr_ack, (c == 7));
      if (c == 1) begin
        chk("split app_cmd", app_cmd, 3'b000);
        chk("split app_addr", app_addr, a0);
        chk("split app_wdf_data", app_wdf_data, d0);
      end
    end
    $display("split write handshake done");

    // Outstanding limit: reads stop at OUTST_MAX with no returns
    @(posedge clk); #1;
    app_wdf_rdy = 1'b0;
    chk("outst start", rd_outst, 0);
    a0 = 28'h1234567;
    rd_req = 1'b1; rd_addr = a0; app_rdy = 1'b1;
    n_ack = 0; n_en = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (app_en) begin
        if (n_en == 0) begin
          chk("limit app_cmd", app_cmd, 3'b001);
          chk("limit app_addr", app_addr, a0);
        end
        n_en++;
      end
      if (rd_ack) n_ack++;
      @(posedge clk); #1;
    end
    chk("limit rd_acks", n_ack, OUTST_MAX);
    chk("limit app_en count", n_en, OUTST_MAX);
    chk("limit rd_outst", rd_outst, OUTST_MAX);
    app_rd_data_valid = 1'b1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("after return rd_outst", rd_outst, OUTST_MAX - 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rd_ack) found = 1'b1;
    end
    chk("fifth read acked", found, 1);
    chk("fifth read rd_outst", rd_outst, OUTST_MAX);
    $display("outstanding limit: %0d reads acked before return", n_ack);

    // Simultaneous accept and return at rd_outst = 2
    @(posedge clk); #1;
    rd_req = 1'b0;
    app_rdy = 1'b0;
    app_rd_data_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("drain to 2", rd_outst, 2);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 28'h0000055;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (app_en) found = 1'b1;
      @(posedge clk); #1;
    end
    chk("simul app_en seen", found, 1);
    app_rdy = 1'b1; app_rd_data_valid = 1'b1;
    @(posedge clk); #1;
    app_rdy = 1'b0; app_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("simul rd_ack", rd_ack, 1);
    chk("simul rd_outst", rd_outst, 2);
    chk("simul app_en low", app_en, 0);
    $display("simultaneous update rd_outst=%0d", rd_outst);

    // Starvation guard pattern with both requests held
    @(posedge clk); #1;
    rd_req = 1'b0;
    app_rd_data_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    chk("drain to 0 saturates", rd_outst, 0);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 28'h0FFF000; wr_data = 64'h1111_2222_3333_4444;
    rd_req = 1'b1; rd_addr = 28'h0EEE000;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    n_ack = 0; n_rd = 0;
    for (int i = 0; i < 300 && n_ack < 18; i++) begin
      @(negedge clk);
      chk("starve one ack", (wr_ack && rd_ack), 0);
      if (wr_ack || rd_ack) begin
        exp_rd = GUARD && ((n_ack % (RUN_MAX + 1)) == RUN_MAX);
        chk($sformatf("starve grant %0d is read", n_ack), rd_ack, exp_rd);
        if (rd_ack) n_rd++;
        n_ack++;
      end
      @(posedge clk); #1;
    end
    chk("starve ack count", n_ack, 18);
    chk("starve rd_outst", rd_outst, n_rd);
    $display("starvation: %0d grants, %0d reads", n_ack, n_rd);
    wr_req = 1'b0; rd_req = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;

    // Reset mid-operation
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 28'h0333333; wr_data = 64'h5555_6666_7777_8888;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (app_en) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("midreset app_en seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post reset wr_ack", wr_ack, 0);
      chk("post reset app_en", app_en, 0);
      @(posedge clk); #1;
    end
    a0 = 28'h0777001;
    wr_req = 1'b1; wr_addr = a0; wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("latency c%0d wr_ack", c), wr_ack, (c == 2));
      chk($sformatf("latency c%0d app_en", c), app_en, (c == 1));
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    $display("reset mid-operation and best-case latency done");

    // Randomized traffic against a transaction-level model
    model_outst = 0;
    exp_wack = 0; exp_rack = 0; w_cmd_seen = 0; w_dat_seen = 0;
    wr_drop = 0; rd_drop = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (wr_drop) begin
        wr_req = 1'b0; wr_drop = 1'b0;
      end else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = {$urandom, $urandom};
      end
      if (rd_drop) begin
        rd_req = 1'b0; rd_drop = 1'b0;
      end else if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1'b1;
        rd_addr = AW'($urandom);
      end
      app_rdy = ($urandom_range(0, 2) != 0);
      app_wdf_rdy = ($urandom_range(0, 2) != 0);
      app_rd_data_valid = (model_outst > 0) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk("rand wr_ack", wr_ack, exp_wack);
      chk("rand rd_ack", rd_ack, exp_rack);
      chk("rand rd_outst", rd_outst, model_outst);
      if (wr_ack) wr_drop = 1'b1;
      if (rd_ack) rd_drop = 1'b1;
      exp_wack = 0; exp_rack = 0; rd_acc = 0;
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          chk("rand dup write cmd", w_cmd_seen, 0);
          chk("rand write cmd with req", wr_req, 1);
          chk("rand write addr", app_addr, wr_addr);
          w_cmd_seen = 1'b1;
        end else begin
          chk("rand read cmd code", app_cmd, 3'b001);
          chk("rand read cmd with req", rd_req, 1);
          chk("rand read addr", app_addr, rd_addr);
          exp_rack = 1'b1;
          rd_acc = 1'b1;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("rand dup write data", w_dat_seen, 0);
        chk("rand write data", app_wdf_data, wr_data);
        chk("rand wdf_end", app_wdf_end, 1);
        w_dat_seen = 1'b1;
      end
      if (w_cmd_seen && w_dat_seen) begin
        exp_wack = 1'b1;
        w_cmd_seen = 1'b0; w_dat_seen = 1'b0;
      end
      if (rd_acc && !app_rd_data_valid) model_outst++;
      else if (!rd_acc && app_rd_data_valid && model_outst > 0) model_outst--;
      if (model_outst > OUTST_MAX) begin
        chk("rand model within limit", model_outst, OUTST_MAX);
        model_outst = OUTST_MAX;
      end
    end
    $display("random phase done, %0d outstanding", model_outst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_rw_arbiter.md
# ddr3_rw_arbiter

Sits between the frame address generator and the DDR3 controller user (app) interface. Shares the single command port between two requesters:
- the write stream (sub-frame pixel bursts);
- the read stream (row-pair fetches for the PWM output).

Sequences one burst per grant, tracks outstanding reads, and holds off all traffic until calibration completes.

## Interface
- MEM_ADDR_SIZE, `MEM_ADDR_SIZE: app/requester address width
- CACHE_WIDTH, `CACHE_WIDTH: burst data width
- WR_RUN_MAX, 8: consecutive write grants allowed while a read waits
- RD_OUTST_MAX, 16: maximum reads issued but not yet returned

Ports:
- clk  in  1  controller user clock
- rst_n  in  1  reset, asynchronous, active-low
- init_calib_complete  in  1  controller ready; no grant while low
- wr_req  in  1  write burst pending; held until wr_ack
- wr_addr  in  MEM_ADDR_SIZE  write burst address; stable while wr_req
- wr_data  in  CACHE_WIDTH  write burst data; stable while wr_req
- wr_ack  out  1  one-cycle pulse: command and data both accepted
- rd_req  in  1  read burst pending; held until rd_ack
- rd_addr  in  MEM_ADDR_SIZE  read burst address
- rd_ack  out  1  one-cycle pulse: read command accepted
- app_en  out  1  command valid
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  MEM_ADDR_SIZE  command address
- app_rdy  in  1  command accepted when high with app_en
- app_wdf_wren  out  1  write data valid
- app_wdf_data  out  CACHE_WIDTH  write data
- app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts)
- app_wdf_rdy  in  1  write data accepted
- app_rd_data_valid  in  1  one read burst returned
- rd_outst  out  5  current outstanding-read count

## Operation

FSM states: IDLE, WR, RD.

IDLE
- Waits for init_calib_complete.
- Grant selection, evaluated each cycle:
  - rd_req and read forced (see Configuration) and rd_outst < RD_OUTST_MAX → RD.
  - else wr_req → WR.
  - else rd_req and rd_outst < RD_OUTST_MAX → RD.
  - else stay.
- On grant, register app_addr, app_cmd and app_wdf_data from the winner.

WR
- app_en and app_wdf_wren asserted from the first WR cycle.
- Each is dropped independently in the cycle after its own ready (app_rdy / app_wdf_rdy) is sampled high.
- When both have been accepted (possibly in the same cycle): pulse wr_ack, go to IDLE.
- Data accepted before command, or command before data: both legal.

RD
- app_en is held until app_rdy is sampled high.
- Then pulse rd_ack, increment rd_outst, go to IDLE.

Outstanding-read counter
- rd_outst increments on an RD command accept and decrements on app_rd_data_valid.
- Simultaneous increment and decrement leaves it unchanged.
- Decrement at 0 is ignored and saturates.
- It never exceeds RD_OUTST_MAX, because RD is only granted below the limit.

Write-run counter
- wr_run counts consecutive write grants.
- Cleared on any read grant, or when rd_req is low in IDLE.
- Saturates at WR_RUN_MAX.

init_calib_complete falling mid-burst
- The current burst completes normally; no new grant is made.

## Timing
- Reset values:
  - app_en = 0, app_wdf_wren = 0, app_wdf_end = 0
  - app_cmd = 3'b000, app_addr = 0, app_wdf_data = 0
  - wr_ack = 0, rd_ack = 0, rd_outst = 0
  - FSM = IDLE, wr_run = 0
- All outputs are registered.
- Grant decision in IDLE cycle N; app_en high in cycle N+1.
- app_rdy high in cycle M → app_en low and ack high in cycle M+1.
- Best-case request-to-ack latency: 2 cycles.
- Minimum spacing between grants: 3 cycles (ack cycle is spent in IDLE).
- Requesters must keep req high through the ack cycle and drop or advance it in the cycle after ack.
  - A req still high after ack is treated as a new request.

## Configuration
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - When wr_run == WR_RUN_MAX and rd_req is high in IDLE, the read is forced, provided rd_outst < RD_OUTST_MAX.
  - The write waits.
- Undefined:
  - Strict write priority; wr_run logic is absent.
  - Reads are served only when wr_req is low.

## Structure
- Shared package/defines file holds:
  - the APP_CMD_WR / APP_CMD_RD encodings;
  - the FSM state encoding;
  - the WR_RUN_MAX and RD_OUTST_MAX defaults.
- One sub-module, ddr3_rd_outst_cnt: the saturating up/down counter with full/empty flags.
- Everything else is inline.

## Test plan
- **Idle gating:** init_calib_complete=0 with wr_req=1 for 20 cycles → app_en stays 0. Raise calib → app_en high 2 cycles later with app_cmd=000 and app_addr=wr_addr.
- **Split write handshake:** app_wdf_rdy high in cycle 3, app_rdy high in cycle 6 → app_wdf_wren drops in cycle 4, app_en drops in cycle 7, single wr_ack in cycle 7.
- **Starvation guard:** with ARB_STARVE_GUARD_EN, WR_RUN_MAX=8, wr_req and rd_req held high → 8 writes, 1 read, 8 writes, and so on. Without the macro → 0 reads.
- **Outstanding limit:** RD_OUTST_MAX=4, rd_req held, app_rd_data_valid held low → 4 rd_acks, rd_outst=4, no fifth app_en. One app_rd_data_valid → fifth read issued.
- **Simultaneous update:** app_rd_data_valid in the same cycle as a read accept with rd_outst=2 → rd_outst remains 2.
- **Reset mid-operation:** rst_n asserted while in WR with app_en high → all outputs return to reset values immediately. After release, no ack until a new full handshake.
